// File: rtl/bcp_pkg.sv
// Shared types for the BCP dispatcher: engine command word and FSM state encoding.
package bcp_pkg;
  localparam int CMD_OFF_W  = 2;
  localparam int CMD_DATA_W = 18;

  typedef struct packed {
    logic                  value;
    logic [CMD_OFF_W-1:0]  offset;
    logic [CMD_DATA_W-1:0] data;
  } te_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} disp_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/bcp_fifo.sv
// Synchronous FIFO of engine commands with a flush that empties it in one cycle.
module bcp_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  te_cmd_t din,
  output te_cmd_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  te_cmd_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push_ok, pop_ok;

  // A push is judged against the current fill level only, so a full FIFO
  // refuses it even when the same cycle pops.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bcp_dispatcher.sv
// Queues implied assignments and issues them one at a time to traversal_engine,
// waiting for FINISH/CONFLICT; conflicts and watchdog expiry halt until CLR.
module bcp_dispatcher
  import bcp_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int OFF_W   = CMD_OFF_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_value,
  input  logic [OFF_W-1:0]  push_offset,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  input  logic              clr,
  output logic              te_en,
  output logic              te_value,
  output logic [OFF_W-1:0]  te_offset,
  output logic [DATA_W-1:0] te_data,
  input  logic              te_finish,
  input  logic              te_conflict,
  output logic              busy,
  output logic              conflict,
  output logic              timeout_err,
  output logic [15:0]       issued_cnt
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  disp_state_t     state, state_nxt;
  te_cmd_t         head, cmd_q;
  logic [WD_W-1:0] wd;
  logic            pop, do_flush, set_conf, set_to, fifo_push;

  assign fifo_push = push && !clr && !conflict && !timeout_err;

  bcp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (do_flush),
    .push  (fifo_push),
    .pop   (pop),
    .din   ('{value: push_value, offset: push_offset, data: push_data}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_flush  = 1'b0;
    set_conf  = 1'b0;
    set_to    = 1'b0;
    case (state)
      IDLE: if (!empty && !conflict && !timeout_err) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (te_conflict) begin
          set_conf  = 1'b1;
          do_flush  = 1'b1;
          state_nxt = HALT;
        end else if (te_finish) begin
          state_nxt = IDLE;
        end else if (TIMEOUT != 0 && wd == WD_MAX) begin
          set_to    = 1'b1;
          do_flush  = 1'b1;
          state_nxt = HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
    // Clear overrides everything, including a pop decided above.
    if (clr) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      set_conf  = 1'b0;
      set_to    = 1'b0;
      do_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      te_en       <= 1'b0;
      cmd_q       <= '0;
      wd          <= '0;
      issued_cnt  <= '0;
      conflict    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      te_en <= pop;
      if (pop) cmd_q <= head;
      if (clr || state != WAIT) wd <= '0;
      else                      wd <= wd + 1'b1;
      if (clr)                  issued_cnt <= '0;
      else if (state == ISSUE)  issued_cnt <= sat_inc16(issued_cnt);
      if (clr) begin
        conflict    <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (set_conf) conflict    <= 1'b1;
        if (set_to)   timeout_err <= 1'b1;
      end
    end
  end

  assign te_value  = cmd_q.value;
  assign te_offset = cmd_q.offset;
  assign te_data   = cmd_q.data;
  assign busy      = (state != IDLE) || !empty;
endmodule

// File: tb/tb_bcp_dispatcher.sv
// Directed scoreboard bench: stimulus queues expected commands, a monitor checks each TE_EN.
module tb_bcp_dispatcher;
  localparam int DEPTH = 8, DATA_W = 18, OFF_W = 2, TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              push = 1'b0, push_value = 1'b0;
  logic [OFF_W-1:0]  push_offset = '0;
  logic [DATA_W-1:0] push_data = '0;
  logic              full, empty, clr = 1'b0;
  logic              te_en, te_value;
  logic [OFF_W-1:0]  te_offset;
  logic [DATA_W-1:0] te_data;
  logic              te_finish = 1'b0, te_conflict = 1'b0;
  logic              busy, conflict, timeout_err;
  logic [15:0]       issued_cnt;

  bcp_dispatcher #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OFF_W(OFF_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_value(push_value),
    .push_offset(push_offset), .push_data(push_data), .full(full), .empty(empty),
    .clr(clr), .te_en(te_en), .te_value(te_value), .te_offset(te_offset),
    .te_data(te_data), .te_finish(te_finish), .te_conflict(te_conflict),
    .busy(busy), .conflict(conflict), .timeout_err(timeout_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [OFF_W-1:0]  o;
    logic [DATA_W-1:0] d;
    int                at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, en_total = 0, en_cyc = -1, served = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every TE_EN must match the oldest expected command.
  always @(negedge clk) begin
    if (rst_n && te_en) begin
      en_total <= en_total + 1;
      en_cyc   <= cyc;
      if (sb.size() == 0) begin
        chk("unexpected_te_en", 32'(te_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("te_value", 32'(te_value), 32'(e.v));
        chk("te_offset", 32'(te_offset), 32'(e.o));
        chk("te_data", 32'(te_data), 32'(e.d));
        if (e.at >= 0) chk("te_en_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic v, input logic [OFF_W-1:0] o,
                          input logic [DATA_W-1:0] d, input bit expect_it, input bit lat);
    exp_t e;
    push = 1'b1; push_value = v; push_offset = o; push_data = d;
    if (expect_it) begin
      e.v = v; e.o = o; e.d = d; e.at = lat ? cyc + 2 : -1;
      sb.push_back(e);
    end
    step(1);
    push = 1'b0;
  endtask

  task automatic wait_en(output int e);
    int t = 0;
    while (en_total == served && t < 64) begin
      step(1);
      t++;
    end
    if (en_total == served) chk("wait_te_en_timeout", 32'(t), 32'(0));
    served++;
    e = en_cyc;
  endtask

  task automatic serve(input int k, output int fin);
    int e;
    wait_en(e);
    while (cyc < e + k) step(1);
    fin = cyc;
    te_finish = 1'b1;
    step(1);
    te_finish = 1'b0;
  endtask

  initial begin
    int fin, prev, e;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_te_en", 32'(te_en), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {30'd0, conflict, timeout_err}, 0);
    chk("rst_cnt", 32'(issued_cnt), 0);
    step(2);
    rst_n = 1'b1;

    // 1) single command latency
    step(1);
    push_cmd(1'b1, 2'd1, 18'd10, 1, 1);
    serve(4, fin);
    chk("t1_issued_cnt", 32'(issued_cnt), 1);

    // 2) three commands back to back, FINISH -> next TE_EN in 2 cycles
    push_cmd(1'b0, 2'd2, 18'd10, 1, 0);
    push_cmd(1'b1, 2'd3, 18'd30, 1, 0);
    push_cmd(1'b0, 2'd0, 18'd50, 1, 0);
    serve(4, prev);
    for (int i = 0; i < 2; i++) begin
      serve(4, fin);
      chk("t2_throughput", 32'(en_cyc), 32'(prev + 2));
      prev = fin;
    end
    step(1);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_cnt", 32'(issued_cnt), 4);

    // 3) overfill while the engine holds one command; 9th push dropped
    push_cmd(1'b1, 2'd0, 18'h3FFFF, 1, 0);
    for (int i = 0; i < 9; i++)
      push_cmd(i[0], i[1:0], 18'(100 + i), (i < 8), 0);
    chk("t3_full", 32'(full), 1);
    for (int i = 0; i < 9; i++) serve(2, fin);
    step(3);
    chk("t3_empty", 32'(empty), 1);
    chk("t3_full_after", 32'(full), 0);
    chk("t3_cnt", 32'(issued_cnt), 13);
    chk("t3_sb_drained", 32'(sb.size()), 0);

    // 4) conflict together with finish; queue flushed, halt until CLR
    push_cmd(1'b1, 2'd1, 18'h155, 1, 0);
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 2'd2, 18'(200 + i), 0, 0);
    wait_en(e);
    while (cyc < e + 2) step(1);
    te_conflict = 1'b1; te_finish = 1'b1;
    step(1);
    te_conflict = 1'b0; te_finish = 1'b0;
    chk("t4_conflict", 32'(conflict), 1);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_busy_halt", 32'(busy), 1);
    push_cmd(1'b1, 2'd3, 18'd77, 0, 0);
    chk("t4_push_dropped", 32'(empty), 1);
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_clr_conflict", 32'(conflict), 0);
    chk("t4_clr_cnt", 32'(issued_cnt), 0);
    chk("t4_clr_idle", 32'(busy), 0);

    // 5) watchdog: TIMEOUT_ERR exactly 16 cycles after entering WAIT
    push_cmd(1'b0, 2'd1, 18'h2AAAA, 1, 1);
    wait_en(e);
    while (cyc < e + 16) step(1);
    chk("t5_not_yet", 32'(timeout_err), 0);
    step(1);
    chk("t5_timeout", 32'(timeout_err), 1);
    push_cmd(1'b1, 2'd1, 18'd5, 0, 0);
    chk("t5_push_ignored", 32'(empty), 1);
    chk("t5_cnt", 32'(issued_cnt), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t5_clr", {30'd0, timeout_err, busy}, 0);

    // 6) async reset in WAIT; a late FINISH issues nothing
    push_cmd(1'b1, 2'd2, 18'h1234, 1, 0);
    push_cmd(1'b0, 2'd1, 18'h0999, 0, 0);
    wait_en(e);
    while (cyc < e + 2) step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_te_data", 32'(te_data), 0);
    chk("t6_te_value", {30'd0, te_value, te_en}, 0);
    chk("t6_cnt", 32'(issued_cnt), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_busy", 32'(busy), 0);
    step(1);
    rst_n = 1'b1;
    te_finish = 1'b1;
    step(1);
    te_finish = 1'b0;
    step(6);
    chk("t6_no_te_en", 32'(en_total), 32'(served));
    chk("t6_sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
